// File: rtl/arb_pkg.sv
// Shared encodings for the two-requester mux arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_e;

  // Mux select values; the same encoding records which side was granted last.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_n.sv
// WIDTH-bit 2:1 multiplexer assembled from bit-level two_one_mux cells.
// Latency: combinational.
// Backpressure: none.
// Ports: a (sel=0), b (sel=1), sel, y.
module mux2_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    two_one_mux u_bit (
      .a   (a[i]),
      .b   (b[i]),
      .sel (sel),
      .y   (y[i])
    );
  end

endmodule

// File: rtl/two_one_mux.sv
// Bit-level 2:1 multiplexer.
// Latency: combinational.
// Backpressure: none.
// Ports: a (sel=0), b (sel=1), sel, y.
module two_one_mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning a shared 2:1 mux between requesters A and B.
// Latency: Req->Gnt 1 cycle from IDLE; beat->Y/Valid 1 cycle.
// Backpressure: a granted side is preempted after MAX_HOLD beats while the other requests.
// Ports: Clk, Rst_n (sync, active-low); ReqA/ReqB + DataA/DataB in;
//        GntA/GntB/Sel decoded from state; Y/Valid registered muxed beat.
module mux_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             GntA,
  output logic             GntB,
  output logic             Sel,
  output logic [WIDTH-1:0] Y,
  output logic             Valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;

  logic             beat;
  logic             enter_a;
  logic             enter_b;
  logic [WIDTH-1:0] mux_y;

  mux2_n #(.WIDTH(WIDTH)) u_mux (
    .a   (DataA),
    .b   (DataB),
    .sel (Sel),
    .y   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    enter_a = 1'b0;
    enter_b = 1'b0;

    beat = ((state_q == GRANT_A) && ReqA) || ((state_q == GRANT_B) && ReqB);

    case (state_q)
      IDLE: begin
        // On a tie, the side that was not granted last wins.
        if (ReqA && (!ReqB || (last_q == SEL_B))) begin
          enter_a = 1'b1;
        end else if (ReqB) begin
          enter_b = 1'b1;
        end
      end
      GRANT_A: begin
        if (!ReqA) begin
          if (ReqB) enter_b = 1'b1;
          else      state_d = IDLE;
        end else if (ReqB && (cnt_q >= HOLD_LAST)) begin
          // This edge carries A's final beat and hands the mux to B.
          enter_b = 1'b1;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GRANT_B: begin
        if (!ReqB) begin
          if (ReqA) enter_a = 1'b1;
          else      state_d = IDLE;
        end else if (ReqA && (cnt_q >= HOLD_LAST)) begin
          enter_a = 1'b1;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_a) begin
      state_d = GRANT_A;
      cnt_d   = '0;
      last_d  = SEL_A;
    end else if (enter_b) begin
      state_d = GRANT_B;
      cnt_d   = '0;
      last_d  = SEL_B;
    end

    // Y holds its last value on non-beat cycles.
    y_d     = beat ? mux_y : y_q;
    valid_d = beat;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SEL_B;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign GntA  = (state_q == GRANT_A);
  assign GntB  = (state_q == GRANT_B);
  assign Sel   = (state_q == GRANT_B) ? SEL_B : SEL_A;
  assign Y     = y_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: expected beats queued by stimulus, popped by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux_arbiter;

  localparam int WIDTH = 8;

  logic             Clk;
  logic             Rst_n;
  logic             ReqA, ReqB;
  logic [WIDTH-1:0] DataA, DataB;
  logic             GntA, GntB, Sel, Valid;
  logic [WIDTH-1:0] Y;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .ReqA  (ReqA),
    .ReqB  (ReqB),
    .DataA (DataA),
    .DataB (DataB),
    .GntA  (GntA),
    .GntB  (GntB),
    .Sel   (Sel),
    .Y     (Y),
    .Valid (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int excl_viol = 0;
  int fair_a = 0;
  int fair_b = 0;
  bit fair_on = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every Valid cycle must match the oldest queued beat.
  always @(negedge Clk) begin
    if (GntA && GntB) excl_viol++;
    if (Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got Y=%0h with no beat expected", Y);
      end else begin
        chk("beat_data", {24'h0, Y}, {24'h0, exp_q.pop_front()});
      end
      if (fair_on) begin
        if (Y == 8'hAA) fair_a++;
        else if (Y == 8'h55) fair_b++;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ga, input logic gb, input logic sel);
    @(negedge Clk);
    chk({tag, "_gnta"}, {31'h0, GntA}, {31'h0, ga});
    chk({tag, "_gntb"}, {31'h0, GntB}, {31'h0, gb});
    chk({tag, "_sel"},  {31'h0, Sel},  {31'h0, sel});
  endtask

  task automatic chk_reset(input string tag);
    chk_outs(tag, 1'b0, 1'b0, 1'b0);
    chk({tag, "_y"},     {24'h0, Y},     32'h0);
    chk({tag, "_valid"}, {31'h0, Valid}, 32'h0);
  endtask

  task automatic push_n(input logic [WIDTH-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  initial begin
    int diff;
    Rst_n = 1'b0; ReqA = 1'b1; ReqB = 1'b1;
    DataA = 8'hA5; DataB = 8'h55;

    // Reset held two cycles with both requesting.
    step(); chk_reset("rst0");
    step(); chk_reset("rst1");

    // Tie after reset: A wins; A releases after 2 beats and B takes over.
    Rst_n = 1'b1;
    step(); chk_outs("tie_grant", 1'b1, 1'b0, 1'b0);
    push_n(8'hA5, 2);
    step(); step();
    ReqA = 1'b0;
    step(); chk_outs("handover", 1'b0, 1'b1, 1'b1);
    push_n(8'h55, 2);
    step(); step();
    ReqB = 1'b0;
    step(); chk_outs("b_release", 1'b0, 1'b0, 1'b0);

    // Single requester: three beats of 5A.
    ReqA = 1'b1; DataA = 8'h5A;
    step(); chk_outs("single_grant", 1'b1, 1'b0, 1'b0);
    push_n(8'h5A, 3);
    step(); step(); step();
    ReqA = 1'b0;
    step(); chk_outs("single_idle", 1'b0, 1'b0, 1'b0);
    chk("single_y_hold", {24'h0, Y}, 32'h5A);
    chk("single_valid_low", {31'h0, Valid}, 32'h0);

    // Preemption: B arrives on A's first granted cycle; A gets exactly 4 beats.
    ReqA = 1'b1; DataA = 8'hAA;
    step(); chk_outs("pre_grant", 1'b1, 1'b0, 1'b0);
    ReqB = 1'b1; DataB = 8'h55;
    push_n(8'hAA, 4);
    step(); step(); step();
    chk_outs("pre_still_a", 1'b1, 1'b0, 1'b0);
    step(); chk_outs("pre_to_b", 1'b0, 1'b1, 1'b1);
    ReqA = 1'b0;
    push_n(8'h55, 2);
    step(); step();
    ReqB = 1'b0;
    step(); chk_outs("pre_idle", 1'b0, 1'b0, 1'b0);

    // Reset during GRANT_B beats: in-flight beat is dropped.
    ReqB = 1'b1;
    step(); chk_outs("mid_grant_b", 1'b0, 1'b1, 1'b1);
    push_n(8'h55, 2);
    step(); step();
    Rst_n = 1'b0; ReqA = 1'b1;
    step(); chk_reset("mid_rst");

    // Fairness: both held for 40 edges from IDLE; A first after reset.
    Rst_n = 1'b1; fair_on = 1'b1;
    step(); chk_outs("fair_first_a", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 39; i++) push_n(((i / 4) % 2 == 0) ? 8'hAA : 8'h55, 1);
    for (int i = 0; i < 39; i++) step();
    ReqA = 1'b0; ReqB = 1'b0;
    step(); step();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("queue_drained", exp_q.size(), 32'h0);
    fair_on = 1'b0;
    chk("fair_total", fair_a + fair_b, 39);
    chk("fair_a", fair_a, 20);
    chk("fair_b", fair_b, 19);
    diff = (fair_a > fair_b) ? fair_a - fair_b : fair_b - fair_a;
    chk("fair_balance", {31'h0, (diff <= 4)}, 32'h1);
    chk("gnt_exclusive", excl_viol, 32'h0);
    chk("end_idle_gnt", {30'h0, GntA, GntB}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
